// File: rtl/event_div_ctrl.sv
// Run-time event divider: synchronizes an async input, passes every R-th pulse at full width
// during a start/stop-sequenced run. Define EVT_DIV_STATS_EN to add the drop_count output.
module event_div_ctrl #(
    parameter int CW          = 8,
    parameter int LW          = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in,
    input  logic          cfg_valid,
    input  logic [CW-1:0] cfg_ratio,
    input  logic [LW-1:0] cfg_limit,
    output logic          cfg_ready,
    input  logic          start,
    input  logic          stop,
    output logic          out,
    output logic          busy,
    output logic          done,
`ifdef EVT_DIV_STATS_EN
    output logic [LW-1:0] drop_count,
`endif
    output logic [LW-1:0] evt_count
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_LOW = 2'd1,
        S_COUNT    = 2'd2,
        S_PASS     = 2'd3
    } state_t;

    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [LW-1:0] LIM_ONE = LW'(1);

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_in_d;
    logic [CW-1:0]          r_ratio;
    logic [LW-1:0]          r_limit;
    logic [CW-1:0]          r_cnt;
    logic [LW-1:0]          r_evt_count;
    logic                   r_stop_pend;
    logic                   r_out;
    logic                   r_done;

    logic                   w_in_s;
    logic                   w_rise;
    logic                   w_fall;
    logic                   w_cfg_ready;
    logic [CW-1:0]          w_ratio_m1;
    logic [LW-1:0]          w_evt_sat;
    logic                   w_run_clr;
    logic                   w_cnt_clr;
    logic                   w_cnt_inc;
    logic                   w_evt_inc;
    logic                   w_done_nxt;

    assign w_in_s      = r_sync[SYNC_STAGES-1];
    assign w_rise      = w_in_s & ~r_in_d;
    assign w_fall      = ~w_in_s & r_in_d;
    assign w_cfg_ready = (r_state == S_IDLE);
    // A programmed ratio of 0 behaves as 1, so the terminal count is 0 in both cases.
    assign w_ratio_m1  = (r_ratio == '0) ? '0 : (r_ratio - CNT_ONE);
    assign w_evt_sat   = (&r_evt_count) ? r_evt_count : (r_evt_count + LIM_ONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync <= '0;
            r_in_d <= 1'b0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], in};
            r_in_d <= w_in_s;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_run_clr   = 1'b0;
        w_cnt_clr   = 1'b0;
        w_cnt_inc   = 1'b0;
        w_evt_inc   = 1'b0;
        w_done_nxt  = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (start && !stop) begin
                    w_run_clr   = 1'b1;
                    w_state_nxt = S_WAIT_LOW;
                end
            end
            S_WAIT_LOW: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (!w_in_s) begin
                    w_state_nxt = S_COUNT;
                end
            end
            S_COUNT: begin
                if (stop) begin
                    w_state_nxt = S_IDLE;
                end else if (w_rise) begin
                    if (r_cnt == w_ratio_m1) begin
                        w_cnt_clr   = 1'b1;
                        w_state_nxt = S_PASS;
                    end else begin
                        w_cnt_inc = 1'b1;
                    end
                end
            end
            S_PASS: begin
                // The pulse is never truncated; stop only takes effect at its falling edge.
                if (w_fall) begin
                    w_evt_inc = 1'b1;
                    if ((r_limit != '0) && (w_evt_sat == r_limit)) begin
                        w_done_nxt  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else if (r_stop_pend || stop) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_COUNT;
                    end
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_ratio     <= CNT_ONE;
            r_limit     <= '0;
            r_cnt       <= '0;
            r_evt_count <= '0;
            r_stop_pend <= 1'b0;
            r_out       <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= w_done_nxt;
            r_out   <= (w_state_nxt == S_PASS) && w_in_s;
            if (cfg_valid && w_cfg_ready) begin
                r_ratio <= cfg_ratio;
                r_limit <= cfg_limit;
            end
            if (w_run_clr || w_cnt_clr) begin
                r_cnt <= '0;
            end else if (w_cnt_inc) begin
                r_cnt <= r_cnt + CNT_ONE;
            end
            if (w_run_clr) begin
                r_evt_count <= '0;
            end else if (w_evt_inc) begin
                r_evt_count <= w_evt_sat;
            end
            if (w_state_nxt == S_IDLE) begin
                r_stop_pend <= 1'b0;
            end else if ((r_state == S_PASS) && stop) begin
                r_stop_pend <= 1'b1;
            end
        end
    end

`ifdef EVT_DIV_STATS_EN
    logic [LW-1:0] r_drop_count;
    logic          w_drop_inc;

    // Only edges seen while counting are drops; WAIT_LOW edges are ignored entirely.
    assign w_drop_inc = (r_state == S_COUNT) && !stop && w_rise && (r_cnt != w_ratio_m1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_drop_count <= '0;
        end else if (w_run_clr) begin
            r_drop_count <= '0;
        end else if (w_drop_inc && !(&r_drop_count)) begin
            r_drop_count <= r_drop_count + LIM_ONE;
        end
    end

    assign drop_count = r_drop_count;
`endif

    assign cfg_ready = w_cfg_ready;
    assign busy      = (r_state != S_IDLE);
    assign out       = r_out;
    assign done      = r_done;
    assign evt_count = r_evt_count;

endmodule
